lzc_denormalizer: RTL
=====================

Name: lzc_denormalizer

Overview:
Inverse of the leading-zero priority encoder in the FP normalization path. Takes a normalized mantissa plus its 3-bit leading-zero count and active flag, and restores the original un-normalized value by shifting right one bit per clock. Also produces the one-hot position of the leading one. Sits on the denormalize/pack side of the FP datapath, with a valid/ready handshake on both sides.

Parameters:
WIDTH, 8, mantissa width in bits; must be a power of two.
CNT_W, 3, leading-zero count width; must equal log2(WIDTH).

Ports:
iClk  input  1  clock; all state changes on the rising edge.
iRst  input  1  asynchronous, active-high reset.
iX  input  WIDTH  normalized mantissa; MSB is expected to be 1 when iAct=1.
iZ  input  CNT_W  leading-zero count, same encoding as the encoder (0 = MSB set).
iAct  input  1  encoder active flag; 0 means the original value was zero.
iValid  input  1  upstream offers iX/iZ/iAct.
oReady  output  1  block can accept; high only in IDLE.
oZ  output  WIDTH  restored value, equal to iX >> iZ.
oOneHot  output  WIDTH  bit (WIDTH-1-iZ) set when iAct=1; all zero otherwise.
oSticky  output  1  a 1 bit was shifted out during restoration (see Optional Feature).
oValid  output  1  oZ/oOneHot/oSticky are valid.
iReady  input  1  downstream accepts the result.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; oZ=0, oOneHot=0, oSticky=0, oValid=0, oReady=1 (combinational from IDLE); shift counter=0.
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - oReady=1.
  - On iValid=1, capture: data reg<=iX, cnt<=iZ, oOneHot<=decode(iZ,iAct), sticky<=0.
  - If iAct=0: data reg<=0 and go to DONE.
  - Else if iZ=0: go to DONE.
  - Else: go to SHIFT.
- SHIFT, each cycle:
  - data<=data>>1 with a zero filled in at the MSB.
  - sticky<=sticky|data[0].
  - cnt<=cnt-1.
  - When cnt==1 (this is the last shift), go to DONE.
- DONE:
  - oValid=1; outputs stay stable while waiting.
  - On iReady=1: go to IDLE in the same edge and drop oValid.
  - A new input cannot be accepted in that same cycle (oReady=0 in DONE), so there is no overlap.
- Latency, counted from the acceptance edge to oValid high:
  - max(iZ,0)+1 cycles when iAct=1; iZ=0 gives 1 cycle and iZ=7 gives 8 cycles.
  - 1 cycle when iAct=0.
- Throughput: one transaction per (latency+1) cycles at minimum.
- iValid while not in IDLE is ignored; upstream must hold iValid until oReady.
- Inputs are sampled only on the acceptance edge; later changes have no effect.
- The counter never underflows; iZ is unsigned, range 0..WIDTH-1.
- iAct=0 with any iZ: oZ=0, oOneHot=0, oSticky=0.
- iX MSB=0 with iAct=1 is not flagged as an error; the shift proceeds as normal.

Optional Feature:
LZC_DENORM_STICKY_EN
- Defined: oSticky reports the OR of every bit shifted out. Non-zero means the input was not a valid normalized value (its low iZ bits were not zero).
- Undefined: the sticky register is not built and oSticky is tied to 0. All other behaviour and timing are identical.

Decomposition:
- Package fp_norm_pkg holds:
  - the WIDTH and CNT_W defaults;
  - the state typedef: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2;
  - the constant for the zero mantissa.
- One natural sub-module, priority_decoder3x8: combinational CNT_W-to-WIDTH decoder, enable=iAct, output bit (WIDTH-1-index). It is the exact inverse of the encoder's index mapping and feeds oOneHot.
- The FSM and shift datapath stay in the top module.

Test Plan:
- Normal shift: iX=8'b1011_0000, iZ=2, iAct=1, iReady=1 -> oValid 3 cycles after acceptance; oZ=8'b0010_1100, oOneHot=8'b0010_0000, oSticky=0.
- Zero count: iX=8'b1000_0001, iZ=0, iAct=1 -> oValid after 1 cycle; oZ=8'b1000_0001, oOneHot=8'b1000_0000.
- Inactive input: iX=8'hFF, iZ=5, iAct=0 -> oValid after 1 cycle; oZ=0, oOneHot=0, oSticky=0.
- Backpressure: iZ=7, iX=8'h80, iReady held low 5 cycles after oValid -> oZ=8'h01 held stable and oReady=0 throughout; IDLE one cycle after iReady rises.
- Sticky, macro defined: iX=8'b1000_0001, iZ=3 -> oZ=8'b0001_0000, oSticky=1. Macro undefined: same oZ, oSticky=0.
- Reset mid-operation: assert iRst 2 cycles into a shift with iZ=6 -> oValid=0, oZ=0 and oReady=1 immediately (asynchronous). The next transaction completes normally.

Source files
------------

// File: rtl/fp_norm_pkg.sv
// Shared defaults, FSM state type and constants for the FP normalize/denormalize path.
package fp_norm_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [WIDTH_DEF-1:0] ZERO_MANT = '0;

endpackage

// File: rtl/lzc_denormalizer_decoder.sv
// Index-to-one-hot decoder: the inverse of the leading-zero encoder mapping (index 0 = MSB).
module priority_decoder3x8
    import fp_norm_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic [CNT_W-1:0] iIdx,
    input  logic             iEn,
    output logic [WIDTH-1:0] oOneHot
);

    always_comb begin
        oOneHot = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            oOneHot[i] = iEn && (iIdx == CNT_W'(WIDTH - 1 - i));
        end
    end

endmodule

// File: rtl/lzc_denormalizer.sv
// Restores an un-normalized mantissa by shifting right one bit per clock.
// Optional sticky tracking of shifted-out bits: define LZC_DENORM_STICKY_EN.
module lzc_denormalizer
    import fp_norm_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic [WIDTH-1:0] iX,
    input  logic [CNT_W-1:0] iZ,
    input  logic             iAct,
    input  logic             iValid,
    output logic             oReady,
    output logic [WIDTH-1:0] oZ,
    output logic [WIDTH-1:0] oOneHot,
    output logic             oSticky,
    output logic             oValid,
    input  logic             iReady
);

    state_t           state;
    logic [WIDTH-1:0] data;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dec;
    logic             sticky;

    priority_decoder3x8 #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_dec (
        .iIdx    (iZ),
        .iEn     (iAct),
        .oOneHot (dec)
    );

    assign oReady  = (state == IDLE);
    assign oZ      = data;
    assign oSticky = sticky;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state   <= IDLE;
            data    <= '0;
            cnt     <= '0;
            oOneHot <= '0;
            oValid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (iValid) begin
                        data    <= iAct ? iX : WIDTH'(ZERO_MANT);
                        cnt     <= iZ;
                        oOneHot <= dec;
                        if (!iAct || iZ == '0) begin
                            state  <= DONE;
                            oValid <= 1'b1;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    data <= data >> 1;
                    cnt  <= cnt - 1'b1;
                    // cnt==1 means this edge performs the final shift
                    if (cnt == CNT_W'(1)) begin
                        state  <= DONE;
                        oValid <= 1'b1;
                    end
                end
                DONE: begin
                    if (iReady) begin
                        state  <= IDLE;
                        oValid <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    oValid <= 1'b0;
                end
            endcase
        end
    end

`ifdef LZC_DENORM_STICKY_EN
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            sticky <= 1'b0;
        end else if (state == IDLE && iValid) begin
            sticky <= 1'b0;
        end else if (state == SHIFT) begin
            sticky <= sticky | data[0];
        end
    end
`else
    assign sticky = 1'b0;
`endif

endmodule
